seq_right_shifter: RTL and testbench

SEQ_RIGHT_SHIFTER -- requirements
Module: seq_right_shifter

---
 rtl/cpu.svh | 19 +
 rtl/cpu_pkg.sv | 2 +
 rtl/shift_step.sv | 17 +
 rtl/seq_right_shifter.sv | 107 ++++++++++
 tb/tb_seq_right_shifter.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/cpu.svh
// Shared CPU definitions: shifter FSM state encoding and datapath width.
// Guarded so it may be pulled into more than one compilation unit.
`ifndef CPU_SVH
`define CPU_SVH

package cpu_pkg;

  localparam int SHIFT_W = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shift_state_t;

endpackage

`endif

// File: rtl/cpu_pkg.sv
// Compilation wrapper that brings the cpu_pkg package (kept in cpu.svh) into the build.
`include "cpu.svh"

// File: rtl/shift_step.sv
// Combinational right shift of data_i by n_i bits (0..4), with vacated MSBs set to fill_i.
module shift_step
  import cpu_pkg::*;
(
  input  logic [SHIFT_W-1:0] data_i,
  input  logic [2:0]         n_i,
  input  logic               fill_i,
  output logic [SHIFT_W-1:0] data_o
);

  logic [2*SHIFT_W-1:0] ext;

  // Shifting a fill-extended word keeps the vacated positions equal to fill_i.
  assign ext    = {{SHIFT_W{fill_i}}, data_i} >> n_i;
  assign data_o = ext[SHIFT_W-1:0];

endmodule

// File: rtl/seq_right_shifter.sv
// Multi-cycle right shifter: STEP bits per SHIFT cycle, valid/ready on both sides.
// Arithmetic shifts are honoured only when SEQ_SHIFT_SRA_EN is defined.
module seq_right_shifter
  import cpu_pkg::*;
#(
  parameter int STEP = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SHIFT_W-1:0] in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic               in_arith,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SHIFT_W-1:0] out_data,
  output logic               busy
);

  generate
    if (!(STEP == 1 || STEP == 2 || STEP == 4)) begin : g_bad_step
      $error("seq_right_shifter: STEP must be 1, 2 or 4");
    end
  endgenerate

  shift_state_t       state_q, state_d;
  logic [SHIFT_W-1:0] data_q, data_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic               fill_q, fill_d;

  logic               accept;
  logic               arith_fill;
  logic [2:0]         step_n;
  logic [SHIFT_W-1:0] shifted;

`ifdef SEQ_SHIFT_SRA_EN
  assign arith_fill = in_arith & in_data[SHIFT_W-1];
`else
  logic unused_arith;
  assign unused_arith = in_arith;
  assign arith_fill   = 1'b0;
`endif

  assign accept = in_valid && in_ready;
  // The last SHIFT cycle may move fewer than STEP bits.
  assign step_n = (rem_q < SHAMT_W'(STEP)) ? rem_q[2:0] : 3'(STEP);

  shift_step u_step (
    .data_i (data_q),
    .n_i    (step_n),
    .fill_i (fill_q),
    .data_o (shifted)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (in_shamt != '0) ? SHIFT : DONE;
      SHIFT:   if (rem_q == SHAMT_W'(step_n)) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    out_data  = data_q;
  end

  always_comb begin
    data_d = data_q;
    rem_d  = rem_q;
    fill_d = fill_q;
    if (state_q == IDLE && accept) begin
      data_d = in_data;
      rem_d  = in_shamt;
      fill_d = arith_fill;
    end else if (state_q == SHIFT) begin
      data_d = shifted;
      rem_d  = rem_q - SHAMT_W'(step_n);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      rem_q  <= '0;
      fill_q <= 1'b0;
    end else begin
      data_q <= data_d;
      rem_q  <= rem_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: tb/tb_seq_right_shifter.sv
// Directed bench: STEP=1 and STEP=4 instances driven by the same requests.
// Arithmetic expectations follow SEQ_SHIFT_SRA_EN.
module tb_seq_right_shifter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic [4:0]  in_shamt = '0;
  logic        in_arith = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready1, out_valid1, busy1;
  logic [31:0] out_data1;
  logic        in_ready4, out_valid4, busy4;
  logic [31:0] out_data4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_right_shifter #(.STEP(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .in_shamt(in_shamt), .in_arith(in_arith),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .busy(busy1)
  );

  seq_right_shifter #(.STEP(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .in_shamt(in_shamt), .in_arith(in_arith),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4), .busy(busy4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge with both units idle.
  task automatic run_txn(input string tag, input logic [31:0] d, input logic [4:0] sh,
                         input logic ar, input logic [31:0] exp,
                         input int lat1_exp, input int lat4_exp, input int stall);
    int cyc;
    int lat1;
    int lat4;
    check($sformatf("%s_rdy1", tag), 32'(in_ready1), 32'd1);
    check($sformatf("%s_rdy4", tag), 32'(in_ready4), 32'd1);
    in_valid = 1'b1; in_data = d; in_shamt = sh; in_arith = ar;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = ~d; in_shamt = 5'd3; in_arith = ~ar;
    cyc = 1; lat1 = 0; lat4 = 0;
    while (1) begin
      if (out_valid1 && lat1 == 0) lat1 = cyc;
      if (out_valid4 && lat4 == 0) lat4 = cyc;
      if ((lat1 != 0 && lat4 != 0) || cyc >= 64) break;
      @(posedge clk); #1;
      cyc++;
    end
    check($sformatf("%s_lat1", tag), 32'(lat1), 32'(lat1_exp));
    check($sformatf("%s_lat4", tag), 32'(lat4), 32'(lat4_exp));
    check($sformatf("%s_data1", tag), out_data1, exp);
    check($sformatf("%s_data4", tag), out_data4, exp);
    in_valid = (stall > 0);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check($sformatf("%s_hold_data1", tag), out_data1, exp);
      check($sformatf("%s_hold_data4", tag), out_data4, exp);
      check($sformatf("%s_hold_rdy1", tag), 32'(in_ready1), 32'd0);
      check($sformatf("%s_hold_rdy4", tag), 32'(in_ready4), 32'd0);
      check($sformatf("%s_hold_vld4", tag), 32'(out_valid4), 32'd1);
    end
    // Request held high across the handshake edge must not be accepted.
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    check($sformatf("%s_bubble_busy1", tag), 32'(busy1), 32'd0);
    check($sformatf("%s_bubble_busy4", tag), 32'(busy4), 32'd0);
    check($sformatf("%s_post_vld1", tag), 32'(out_valid1), 32'd0);
    $display("TXN %s data=%h shamt=%0d arith=%0d out1=%h out4=%h lat1=%0d lat4=%0d",
             tag, d, sh, ar, out_data1, out_data4, lat1, lat4);
  endtask

  initial begin
    int seen;
    rst = 1'b1;
    #2;
    check("rst_rdy1", 32'(in_ready1), 32'd1);
    check("rst_vld1", 32'(out_valid1), 32'd0);
    check("rst_busy4", 32'(busy4), 32'd0);
    check("rst_data1", out_data1, 32'd0);
    check("rst_data4", out_data4, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_txn("srl_31", 32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001, 32, 9, 0);
    run_txn("sh0", 32'hDEAD_BEEF, 5'd0, 1'b0, 32'hDEAD_BEEF, 1, 1, 0);
`ifdef SEQ_SHIFT_SRA_EN
    run_txn("sra_4", 32'h8000_0000, 5'd4, 1'b1, 32'hF800_0000, 5, 2, 0);
    run_txn("sra_5", 32'hF000_0000, 5'd5, 1'b1, 32'hFF80_0000, 6, 3, 0);
`else
    run_txn("sra_4", 32'h8000_0000, 5'd4, 1'b1, 32'h0800_0000, 5, 2, 0);
    run_txn("sra_5", 32'hF000_0000, 5'd5, 1'b1, 32'h0780_0000, 6, 3, 0);
`endif
    run_txn("srl_2", 32'h0003_FFFC, 5'd2, 1'b0, 32'h0000_FFFF, 3, 2, 0);
    run_txn("srl_7_stall", 32'hFFFF_FFFF, 5'd7, 1'b0, 32'h01FF_FFFF, 8, 3, 5);
    run_txn("sra_pos31", 32'h7FFF_FFFF, 5'd31, 1'b1, 32'h0000_0000, 32, 9, 0);

    // Reset in the third SHIFT cycle of both units.
    in_valid = 1'b1; in_data = 32'hFFFF_FFFF; in_shamt = 5'd31; in_arith = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("mid_busy1", 32'(busy1), 32'd1);
    check("mid_busy4", 32'(busy4), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_rdy1", 32'(in_ready1), 32'd1);
    check("arst_rdy4", 32'(in_ready4), 32'd1);
    check("arst_vld1", 32'(out_valid1), 32'd0);
    check("arst_busy1", 32'(busy1), 32'd0);
    check("arst_busy4", 32'(busy4), 32'd0);
    check("arst_data1", out_data1, 32'd0);
    check("arst_data4", out_data4, 32'd0);
    #1 rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid1 || out_valid4) seen = 1;
    end
    check("arst_no_valid", 32'(seen), 32'd0);
    $display("TXN reset_mid_shift discarded seen_valid=%0d", seen);

    run_txn("after_rst", 32'h0000_0100, 5'd8, 1'b0, 32'h0000_0001, 9, 3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
